// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - signal bundle between core, fetch logic, arbiter and memory bus
// Signals:
//   MEM side   : load_MEM, MemWrite_MEM, ALUres_MEM, MemWd_MEM -> arbiter; mem_rdata, mem_stall_MEM <- arbiter
//   fetch side : if_req, if_addr, if_hold -> arbiter; if_rdata, if_stall <- arbiter
//   memory bus : bus_rdata, bus_ack -> arbiter; bus_req, bus_we, bus_addr, bus_wdata, bus_err <- arbiter
// Modports: master = the arbiter (it masters the bus), slave = core/fetch/memory environment.
interface mem_port_arbiter_if;
  logic        load_MEM;
  logic        MemWrite_MEM;
  logic [31:0] ALUres_MEM;
  logic [31:0] MemWd_MEM;
  logic [31:0] mem_rdata;
  logic        mem_stall_MEM;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_hold;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  modport master (
    input  load_MEM, MemWrite_MEM, ALUres_MEM, MemWd_MEM,
    input  if_req, if_addr, if_hold,
    input  bus_rdata, bus_ack,
    output mem_rdata, mem_stall_MEM, if_rdata, if_stall,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_err
  );

  modport slave (
    output load_MEM, MemWrite_MEM, ALUres_MEM, MemWd_MEM,
    output if_req, if_addr, if_hold,
    output bus_rdata, bus_ack,
    input  mem_rdata, mem_stall_MEM, if_rdata, if_stall,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one req/ack memory bus between MEM-stage data and fetch
// Ports:
//   clk  : single clock, all state changes on its rising edge
//   rst  : asynchronous active-high reset
//   port : mem_port_arbiter_if.master (MEM side, fetch side and memory bus signals)
// Parameter TIMEOUT (1..1023): bus cycles without bus_ack before an access is aborted.
module mem_port_arbiter #(
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.master port
);

  typedef enum logic [2:0] {IDLE, DATA, INST, D_DONE, I_DONE} state_t;

  // Timeout fires in the cycle whose count would make TIMEOUT bus cycles.
  localparam logic [9:0] CNT_LIMIT = 10'(TIMEOUT - 1);

  state_t      state, state_next;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mrd_q, mrd_d;
  logic [31:0] ird_q, ird_d;
  logic        err_q, err_d;
  logic        last_data_q, last_data_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        data_pend;
  logic        timeout_hit;

  assign data_pend   = port.load_MEM | port.MemWrite_MEM;
  assign timeout_hit = (cnt_q >= CNT_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      mrd_q       <= 32'h0;
      ird_q       <= 32'h0;
      err_q       <= 1'b0;
      last_data_q <= 1'b0;
      cnt_q       <= 10'h0;
    end else begin
      state       <= state_next;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mrd_q       <= mrd_d;
      ird_q       <= ird_d;
      err_q       <= err_d;
      last_data_q <= last_data_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_next  = state;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mrd_d       = mrd_q;
    ird_d       = ird_q;
    err_d       = err_q;
    last_data_d = last_data_q;
    cnt_d       = cnt_q;
    case (state)
      IDLE: begin
        // With both sides pending, data wins unless it was served last.
        if (data_pend && (!port.if_req || !last_data_q)) begin
          state_next = DATA;
          req_d      = 1'b1;
          we_d       = port.MemWrite_MEM;
          addr_d     = port.ALUres_MEM;
          wdata_d    = port.MemWd_MEM;
          cnt_d      = 10'h0;
        end else if (port.if_req) begin
          state_next = INST;
          req_d      = 1'b1;
          we_d       = 1'b0;
          addr_d     = port.if_addr;
          wdata_d    = 32'h0;
          cnt_d      = 10'h0;
        end
      end
      DATA, INST: begin
        cnt_d = (cnt_q == 10'h3FF) ? cnt_q : cnt_q + 10'd1;
        // An ack in the expiry cycle still counts as a good completion.
        if (port.bus_ack || timeout_hit) begin
          req_d = 1'b0;
          if (!port.bus_ack) begin
            err_d = 1'b1;
          end
          if (state == DATA) begin
            state_next  = D_DONE;
            last_data_d = 1'b1;
            if (!we_q) begin
              mrd_d = port.bus_ack ? port.bus_rdata : 32'h0;
            end
          end else begin
            state_next  = I_DONE;
            last_data_d = 1'b0;
            ird_d       = port.bus_ack ? port.bus_rdata : 32'h0;
          end
        end
      end
      D_DONE: state_next = IDLE;
      I_DONE: begin
        if (!port.if_hold) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign port.bus_req       = req_q;
  assign port.bus_we        = we_q;
  assign port.bus_addr      = addr_q;
  assign port.bus_wdata     = wdata_q;
  assign port.bus_err       = err_q;
  assign port.mem_rdata     = mrd_q;
  assign port.if_rdata      = ird_q;
  assign port.mem_stall_MEM = data_pend & (state != D_DONE);
  assign port.if_stall      = port.if_req & (state != I_DONE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int TO = 4;

  logic clk;
  logic rst;
  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst  (rst),
    .port (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.load_MEM = 1'b0; bus.MemWrite_MEM = 1'b0; bus.ALUres_MEM = 32'h0; bus.MemWd_MEM = 32'h0;
    bus.if_req = 1'b0; bus.if_addr = 32'h0; bus.if_hold = 1'b0;
    bus.bus_ack = 1'b0; bus.bus_rdata = 32'h11111111;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: tracks which side owns the bus, how long it has waited,
  // and which side is in its one-shot/held completion window.
  int          m_owner;      // -1 none, 0 data, 1 instruction
  int          m_wait;
  bit          m_data_done, m_inst_done, m_last_data;
  logic        e_req, e_we, e_err;
  logic [31:0] e_addr, e_wdata, e_mrd, e_ird;

  task automatic model_reset();
    m_owner = -1; m_wait = 0; m_data_done = 0; m_inst_done = 0; m_last_data = 0;
    e_req = 0; e_we = 0; e_err = 0; e_addr = 0; e_wdata = 0; e_mrd = 0; e_ird = 0;
  endtask

  task automatic model_step();
    bit dp;
    dp = bus.load_MEM | bus.MemWrite_MEM;
    if (m_data_done) begin
      m_data_done = 0;
    end else if (m_inst_done) begin
      if (!bus.if_hold) m_inst_done = 0;
    end else if (m_owner >= 0) begin
      m_wait++;
      if (bus.bus_ack || m_wait >= TO) begin
        e_req = 0;
        if (!bus.bus_ack) e_err = 1;
        if (m_owner == 0) begin
          m_data_done = 1;
          if (!e_we) e_mrd = bus.bus_ack ? bus.bus_rdata : 32'h0;
        end else begin
          m_inst_done = 1;
          e_ird = bus.bus_ack ? bus.bus_rdata : 32'h0;
        end
        m_last_data = (m_owner == 0);
        m_owner = -1;
      end
    end else if (dp && (!bus.if_req || !m_last_data)) begin
      m_owner = 0; m_wait = 0; e_req = 1;
      e_we = bus.MemWrite_MEM; e_addr = bus.ALUres_MEM; e_wdata = bus.MemWd_MEM;
    end else if (bus.if_req) begin
      m_owner = 1; m_wait = 0; e_req = 1;
      e_we = 0; e_addr = bus.if_addr; e_wdata = 32'h0;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic        ld, st;
    logic [31:0] addr, wd;
    logic        ack;
    logic [31:0] rdata;
    logic        stall, req, we;
    logic [31:0] baddr, bwdata, mrd;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic ld, input logic st, input logic [31:0] addr, input logic [31:0] wd,
                         input logic ack, input logic [31:0] rdata, input logic stall, input logic req,
                         input logic we, input logic [31:0] baddr, input logic [31:0] bwdata,
                         input logic [31:0] mrd);
    vec_t v;
    v.ld = ld; v.st = st; v.addr = addr; v.wd = wd; v.ack = ack; v.rdata = rdata;
    v.stall = stall; v.req = req; v.we = we; v.baddr = baddr; v.bwdata = bwdata; v.mrd = mrd;
    tbl.push_back(v);
  endtask

  logic [31:0] gr[8];
  int          ngr;
  logic        prev_req;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    #2;
    chk1("reset_bus_req", bus.bus_req, 1'b0);
    chk1("reset_bus_err", bus.bus_err, 1'b0);
    chk1("reset_if_stall", bus.if_stall, 1'b0);
    chk32("reset_if_rdata", bus.if_rdata, 32'h0);
    reset_dut();

    //      ld st addr          wd            ack rdata          stall req we baddr        bwdata        mrd
    add_vec(0, 0, 32'h0,        32'h0,        1, 32'h00000BAD, 0,    0,  0, 32'h0,        32'h0,        32'h0);
    add_vec(1, 0, 32'h100,      32'h0,        0, 32'h11111111, 1,    0,  0, 32'h0,        32'h0,        32'h0);
    add_vec(1, 0, 32'h100,      32'h0,        0, 32'h22222222, 1,    1,  0, 32'h100,      32'h0,        32'h0);
    add_vec(1, 0, 32'h100,      32'h0,        0, 32'h33333333, 1,    1,  0, 32'h100,      32'h0,        32'h0);
    add_vec(1, 0, 32'h100,      32'h0,        1, 32'hCAFEF00D, 1,    1,  0, 32'h100,      32'h0,        32'h0);
    add_vec(1, 0, 32'h100,      32'h0,        0, 32'h44444444, 0,    0,  0, 32'h100,      32'h0,        32'hCAFEF00D);
    add_vec(0, 0, 32'h0,        32'h0,        0, 32'h55555555, 0,    0,  0, 32'h100,      32'h0,        32'hCAFEF00D);
    add_vec(0, 1, 32'h200,      32'h12345678, 0, 32'h66666666, 1,    0,  0, 32'h100,      32'h0,        32'hCAFEF00D);
    add_vec(0, 1, 32'h200,      32'h12345678, 0, 32'h77777777, 1,    1,  1, 32'h200,      32'h12345678, 32'hCAFEF00D);
    add_vec(0, 1, 32'h200,      32'h12345678, 1, 32'hDEADBEEF, 1,    1,  1, 32'h200,      32'h12345678, 32'hCAFEF00D);
    add_vec(0, 1, 32'h200,      32'h12345678, 0, 32'h88888888, 0,    0,  1, 32'h200,      32'h12345678, 32'hCAFEF00D);
    add_vec(0, 0, 32'h0,        32'h0,        0, 32'h99999999, 0,    0,  1, 32'h200,      32'h12345678, 32'hCAFEF00D);

    foreach (tbl[k]) begin
      bus.load_MEM = tbl[k].ld; bus.MemWrite_MEM = tbl[k].st;
      bus.ALUres_MEM = tbl[k].addr; bus.MemWd_MEM = tbl[k].wd;
      bus.bus_ack = tbl[k].ack; bus.bus_rdata = tbl[k].rdata;
      @(negedge clk);
      chk1($sformatf("tbl%0d_stall", k), bus.mem_stall_MEM, tbl[k].stall);
      chk1($sformatf("tbl%0d_req", k), bus.bus_req, tbl[k].req);
      chk1($sformatf("tbl%0d_we", k), bus.bus_we, tbl[k].we);
      chk32($sformatf("tbl%0d_addr", k), bus.bus_addr, tbl[k].baddr);
      chk32($sformatf("tbl%0d_wdata", k), bus.bus_wdata, tbl[k].bwdata);
      chk32($sformatf("tbl%0d_mrd", k), bus.mem_rdata, tbl[k].mrd);
      chk1($sformatf("tbl%0d_if_stall", k), bus.if_stall, 1'b0);
      next_cycle();
    end
    idle_inputs();

    // Timeout with no ack: four bus cycles, then zero data and a sticky error.
    bus.load_MEM = 1'b1; bus.ALUres_MEM = 32'h300;
    @(negedge clk);
    chk1("to_err_before", bus.bus_err, 1'b0);
    chk1("to_stall_idle", bus.mem_stall_MEM, 1'b1);
    next_cycle();
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      chk1($sformatf("to_req_c%0d", c), bus.bus_req, 1'b1);
      chk1($sformatf("to_stall_c%0d", c), bus.mem_stall_MEM, 1'b1);
      next_cycle();
    end
    @(negedge clk);
    chk1("to_req_done", bus.bus_req, 1'b0);
    chk1("to_err_done", bus.bus_err, 1'b1);
    chk1("to_stall_done", bus.mem_stall_MEM, 1'b0);
    chk32("to_mrd_zero", bus.mem_rdata, 32'h0);
    next_cycle();
    bus.load_MEM = 1'b0;
    next_cycle();
    bus.load_MEM = 1'b1; bus.ALUres_MEM = 32'h304;
    next_cycle();
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'h77;
    @(negedge clk);
    chk1("to2_req", bus.bus_req, 1'b1);
    next_cycle();
    bus.bus_ack = 1'b0;
    @(negedge clk);
    chk32("to2_mrd", bus.mem_rdata, 32'h77);
    chk1("to2_err_sticky", bus.bus_err, 1'b1);
    next_cycle();
    idle_inputs();

    // Reset pulsed between edges in the middle of a store.
    bus.MemWrite_MEM = 1'b1; bus.ALUres_MEM = 32'h500; bus.MemWd_MEM = 32'hA5A5A5A5;
    next_cycle();
    @(negedge clk);
    chk1("rst_pre_req", bus.bus_req, 1'b1);
    chk32("rst_pre_wdata", bus.bus_wdata, 32'hA5A5A5A5);
    #2;
    bus.MemWrite_MEM = 1'b0;
    rst = 1'b1;
    #1;
    chk1("rst_req", bus.bus_req, 1'b0);
    chk1("rst_we", bus.bus_we, 1'b0);
    chk32("rst_addr", bus.bus_addr, 32'h0);
    chk32("rst_wdata", bus.bus_wdata, 32'h0);
    chk1("rst_err", bus.bus_err, 1'b0);
    chk32("rst_mrd", bus.mem_rdata, 32'h0);
    chk1("rst_stall", bus.mem_stall_MEM, 1'b0);
    #1;
    rst = 1'b0;
    next_cycle();
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk1("stray_req", bus.bus_req, 1'b0);
    next_cycle();
    bus.bus_ack = 1'b0;
    @(negedge clk);
    chk1("stray_req2", bus.bus_req, 1'b0);
    chk32("stray_mrd", bus.mem_rdata, 32'h0);
    chk32("stray_ird", bus.if_rdata, 32'h0);
    chk1("stray_err", bus.bus_err, 1'b0);
    next_cycle();

    // Both sides permanently pending, ack in the first bus cycle: grants alternate.
    reset_dut();
    bus.load_MEM = 1'b1; bus.ALUres_MEM = 32'hD0; bus.if_req = 1'b1; bus.if_addr = 32'h10;
    for (int k = 0; k < 8; k++) gr[k] = 32'h0;
    ngr = 0; prev_req = 1'b0;
    for (int c = 0; c < 16; c++) begin
      bus.bus_ack = bus.bus_req;
      bus.bus_rdata = 32'h1000 + 32'(c);
      if (bus.bus_req && !prev_req && ngr < 8) begin
        gr[ngr] = bus.bus_addr;
        ngr++;
      end
      prev_req = bus.bus_req;
      next_cycle();
    end
    chk1("alt_grant_count", ngr >= 4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk32($sformatf("alt_grant%0d", k), gr[k], (k % 2 == 0) ? 32'hD0 : 32'h10);
    end
    idle_inputs();

    // Fetch completes, then IF/ID held for five cycles.
    reset_dut();
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    @(negedge clk);
    chk1("hold_if_stall_idle", bus.if_stall, 1'b1);
    next_cycle();
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'h600D1234;
    @(negedge clk);
    chk32("hold_addr", bus.bus_addr, 32'h40);
    next_cycle();
    for (int c = 0; c < 5; c++) begin
      bus.if_hold = 1'b1;
      bus.bus_ack = (c == 1);
      bus.bus_rdata = 32'hBADBAD00 + 32'(c);
      @(negedge clk);
      chk1($sformatf("hold_if_stall_c%0d", c), bus.if_stall, 1'b0);
      chk32($sformatf("hold_ird_c%0d", c), bus.if_rdata, 32'h600D1234);
      chk1($sformatf("hold_req_c%0d", c), bus.bus_req, 1'b0);
      next_cycle();
    end
    bus.if_hold = 1'b0; bus.bus_ack = 1'b0;
    @(negedge clk);
    chk1("hold_release_stall", bus.if_stall, 1'b0);
    next_cycle();
    bus.if_addr = 32'h44;
    @(negedge clk);
    chk1("hold_back_idle_stall", bus.if_stall, 1'b1);
    chk1("hold_back_idle_req", bus.bus_req, 1'b0);
    next_cycle();
    @(negedge clk);
    chk1("hold_next_req", bus.bus_req, 1'b1);
    chk32("hold_next_addr", bus.bus_addr, 32'h44);
    next_cycle();

    // Random traffic against the reference model.
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 9);
      bus.load_MEM = (r < 3);
      bus.MemWrite_MEM = (r >= 3 && r < 6);
      bus.ALUres_MEM = $urandom;
      bus.MemWd_MEM = $urandom;
      bus.if_req = ($urandom_range(0, 2) != 0);
      bus.if_addr = $urandom;
      bus.if_hold = ($urandom_range(0, 1) == 1);
      bus.bus_ack = ($urandom_range(0, 2) == 0);
      bus.bus_rdata = $urandom;
      @(negedge clk);
      chk1("rnd_stall", bus.mem_stall_MEM, (bus.load_MEM | bus.MemWrite_MEM) & !m_data_done);
      chk1("rnd_if_stall", bus.if_stall, bus.if_req & !m_inst_done);
      chk1("rnd_req", bus.bus_req, e_req);
      chk1("rnd_we", bus.bus_we, e_we);
      chk1("rnd_err", bus.bus_err, e_err);
      chk32("rnd_addr", bus.bus_addr, e_addr);
      chk32("rnd_wdata", bus.bus_wdata, e_wdata);
      chk32("rnd_mrd", bus.mem_rdata, e_mrd);
      chk32("rnd_ird", bus.if_rdata, e_ird);
      @(posedge clk);
      model_step();
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
